// File: rtl/timecnt_pkg.sv
// Shared types and helpers for arbitrating time-counter readout streams onto one FIFO port.
package timecnt_pkg;

  localparam int unsigned MaxReq     = 8;
  localparam logic [7:0]  PadDefault = 8'hFF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StClose = 2'd2,
    StGap   = 2'd3
  } state_e;

  // First set bit of req searching from ptr+1 upward, wrapping at nreq; ptr if req is empty.
  function automatic logic [2:0] rr_pick(input logic [MaxReq-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int unsigned       nreq);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned off = 1; off <= MaxReq; off++) begin
      idx = (32'(ptr) + off) % nreq;
      if (off <= nreq && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_arbiter_rr_select.sv
// Combinational round-robin priority encoder: request vector and last winner in, next winner out.
module rr_select
  import timecnt_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [2:0]      idx_o,
  output logic            any_o
);

  logic [MaxReq-1:0] req_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req_i;
    any_o               = |req_i;
    idx_o               = rr_pick(req_ext, ptr_i, NREQ);
    onehot_o            = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      onehot_o[i] = any_o && (idx_o == 3'(i));
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Frame-granular round-robin sharing of one packet FIFO write port between NREQ byte streams,
// with backpressure pass-through and forced close of stalled frames.
module fifo_arbiter
  import timecnt_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [7:0]  PAD     = PadDefault
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     rq,
  input  logic [NREQ-1:0]     wr,
  input  logic [8*NREQ-1:0]   data,
  input  logic [NREQ-1:0]     last,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rbusy,
  output logic                f_write,
  output logic [7:0]          f_data,
  output logic                f_flag,
  input  logic                f_busy,
  output logic [2:0]          owner,
  output logic                abort
);

  localparam int unsigned      TW       = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]    TimerMax = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      rr_q, rr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            f_write_q, f_write_d;
  logic [7:0]      f_data_q, f_data_d;
  logic            f_flag_q, f_flag_d;
  logic            abort_q, abort_d;

  logic [NREQ-1:0] pick_oh;
  logic [2:0]      pick_idx;
  logic            pick_any;
  logic [7:0]      sel_byte;
  logic            sel_last;
  logic            accept;

  rr_select #(
    .NREQ (NREQ)
  ) u_rr_select (
    .req_i    (rq),
    .ptr_i    (rr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign rbusy  = ~gnt_q | {NREQ{f_busy}};
  assign accept = |(wr & ~rbusy);

  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        sel_byte = data[8*i +: 8];
        sel_last = last[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    f_write_d = 1'b0;
    f_data_d  = f_data_q;
    f_flag_d  = 1'b0;
    abort_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          rr_d    = pick_idx;
          timer_d = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // An accepted last byte beats a coincident timer expiry.
        if (accept) begin
          f_write_d = 1'b1;
          f_data_d  = sel_byte;
          f_flag_d  = sel_last;
          timer_d   = '0;
          if (sel_last) begin
            gnt_d   = '0;
            state_d = StGap;
          end
        end else if (timer_q == TimerMax) begin
          gnt_d   = '0;
          state_d = StClose;
        end else if (!f_busy) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StClose: begin
        if (!f_busy) begin
          f_write_d = 1'b1;
          f_data_d  = PAD;
          f_flag_d  = 1'b1;
          abort_d   = 1'b1;
          state_d   = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_q      <= 3'(NREQ - 1);
      timer_q   <= '0;
      f_write_q <= 1'b0;
      f_data_q  <= '0;
      f_flag_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      f_write_q <= f_write_d;
      f_data_q  <= f_data_d;
      f_flag_q  <= f_flag_d;
      abort_q   <= abort_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign f_write = f_write_q;
  assign f_data  = f_data_q;
  assign f_flag  = f_flag_q;
  assign abort   = abort_q;

endmodule
